// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO; frames are start, DATA_BITS LSB-first, optional parity, stop.
// Define UART_TX_PARITY_EN to enable the parity bit selected by parity_mode.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [1:0]                    parity_mode,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_full,
  output logic                          fifo_empty
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [AW:0]      FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // FIFO storage and pointers
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0] rd_word;
  logic                 push, pop;

  assign fifo_full  = (fifo_count == FULL_CNT);
  assign fifo_empty = (fifo_count == '0);
  assign s_ready    = !fifo_full;
  assign push       = s_valid && s_ready;
  assign rd_word    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= s_data[DATA_BITS-1:0];
  end

  // Transmit FSM
  state_t               state, state_nx;
  logic [CNT_W-1:0]     clk_cnt, cnt_nx;
  logic [IDX_W-1:0]     bit_idx, idx_nx;
  logic [DATA_BITS-1:0] shift_q, shift_nx;
  logic                 tx_nx;
  logic                 load;
  logic                 par_en_q, par_en_nx;
  logic                 par_bit_q, par_bit_nx;

  always_comb begin
    state_nx   = state;
    cnt_nx     = clk_cnt + 1'b1;
    idx_nx     = bit_idx;
    shift_nx   = shift_q;
    tx_nx      = tx;
    par_en_nx  = par_en_q;
    par_bit_nx = par_bit_q;
    load       = 1'b0;
    pop        = 1'b0;
    tx_done    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        tx_nx  = 1'b1;
        load   = !fifo_empty;
      end
      START: begin
        if (clk_cnt == BIT_LAST) begin
          state_nx = DATA;
          cnt_nx   = '0;
          idx_nx   = '0;
          tx_nx    = shift_q[0];
        end
      end
      DATA: begin
        if (clk_cnt == BIT_LAST) begin
          cnt_nx = '0;
          if (bit_idx == IDX_LAST) begin
            state_nx = STOP;
            tx_nx    = 1'b1;
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_nx = PARITY;
              tx_nx    = par_bit_q;
            end
`endif
          end else begin
            idx_nx   = bit_idx + 1'b1;
            shift_nx = shift_q >> 1;
            tx_nx    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (clk_cnt == BIT_LAST) begin
          state_nx = STOP;
          cnt_nx   = '0;
          tx_nx    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (clk_cnt == STOP_LAST) begin
          tx_done  = 1'b1;
          state_nx = IDLE;
          tx_nx    = 1'b1;
          load     = !fifo_empty;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Popping a word always launches its start bit on the next cycle.
    if (load) begin
      pop      = 1'b1;
      state_nx = START;
      cnt_nx   = '0;
      tx_nx    = 1'b0;
      shift_nx = rd_word;
`ifdef UART_TX_PARITY_EN
      par_en_nx  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
      par_bit_nx = parity_bit(rd_word, parity_mode[1]);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      par_en_q <= 1'b0;
    end else begin
      state    <= state_nx;
      tx       <= tx_nx;
      clk_cnt  <= cnt_nx;
      bit_idx  <= idx_nx;
      par_en_q <= par_en_nx;
    end
  end

  always_ff @(posedge clk) begin
    shift_q   <= shift_nx;
    par_bit_q <= par_bit_nx;
  end

  assign tx_busy = (state != IDLE);

  // Upper s_data bits and, without parity support, parity_mode are intentionally ignored.
  logic unused_inputs;
  assign unused_inputs = ^{parity_mode, s_data};

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based line model checked every cycle, plus directed literal checks.
module tb_uart_tx_fifo;
  localparam int CPB = 4, DB = 8, SB = 1, DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FL = 4 * (10 + (PAR_EN ? 1 : 0));

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1, s_valid = 1'b0, s_ready;
  logic [7:0] s_data = 8'h00;
  logic [1:0] parity_mode = 2'b00;
  logic       tx, tx_busy, tx_done, fifo_full, fifo_empty;
  logic [2:0] fifo_count;

  logic       r_reset = 1'b1, r_valid = 1'b0, r_ready;
  logic [7:0] r_data = 8'h00;
  logic [1:0] r_mode = 2'b00;
  logic       r_tx, r_busy, r_done, r_full, r_empty;
  logic [2:0] r_count;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .parity_mode(parity_mode), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done),
    .fifo_count(fifo_count), .fifo_full(fifo_full), .fifo_empty(fifo_empty));

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(5), .STOP_BITS(2), .FIFO_DEPTH(4)) dut5 (
    .clk(clk), .reset(r_reset), .s_data(r_data), .s_valid(r_valid), .s_ready(r_ready),
    .parity_mode(r_mode), .tx(r_tx), .tx_busy(r_busy), .tx_done(r_done),
    .fifo_count(r_count), .fifo_full(r_full), .fifo_empty(r_empty));

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Model: word queue plus the exact per-cycle line waveform still to be sent.
  logic [7:0] mq[$];
  bit         line[$];

  task automatic build_frame(input logic [7:0] d, input logic [1:0] m);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) bits.push_back(d[i]);
    if (PAR_EN && (m == 2'b01 || m == 2'b10)) bits.push_back((^d) ^ (m == 2'b10));
    for (int i = 0; i < SB; i++) bits.push_back(1'b1);
    foreach (bits[k]) repeat (CPB) line.push_back(bits[k]);
  endtask

  task automatic model_step(input bit rst, input bit v, input logic [7:0] d, input logic [1:0] m);
    bit acc;
    if (rst) begin
      mq.delete();
      line.delete();
    end else begin
      acc = v && (mq.size() < DEPTH);
      if (line.size() > 0) void'(line.pop_front());
      if (line.size() == 0 && mq.size() > 0) build_frame(mq.pop_front(), m);
      if (acc) mq.push_back(d);
    end
  endtask

  bit         p_rst = 1'b1, p_v = 1'b0;
  logic [7:0] p_d = 8'h00;
  logic [1:0] p_m = 2'b00;
  int         cyc = 0;
  logic       txlog [0:8191];
  logic       r_txlog [0:8191];
  int         busy_cnt, done_cnt, first_busy, last_busy, max_cnt;
  bit         saw_block;
  int         r_busy_cnt, r_done_cnt, r_first, r_last, r_done_cyc;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      model_step(p_rst, p_v, p_d, p_m);
      check("tx",         tx,         (line.size() > 0) ? line[0] : 1'b1);
      check("tx_busy",    tx_busy,    line.size() > 0);
      check("tx_done",    tx_done,    line.size() == 1);
      check("fifo_count", fifo_count, mq.size());
      check("fifo_empty", fifo_empty, mq.size() == 0);
      check("fifo_full",  fifo_full,  mq.size() == DEPTH);
      check("s_ready",    s_ready,    mq.size() != DEPTH);
      p_rst = reset; p_v = s_valid; p_d = s_data; p_m = parity_mode;
      if (cyc < 8192) begin
        txlog[cyc]   = tx;
        r_txlog[cyc] = r_tx;
      end
      if (tx_busy === 1'b1) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = cyc;
        last_busy = cyc;
      end
      if (tx_done === 1'b1) done_cnt++;
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (s_ready === 1'b0 && fifo_count == 3'd4) saw_block = 1'b1;
      if (r_busy === 1'b1) begin
        r_busy_cnt++;
        if (r_first < 0) r_first = cyc;
        r_last = cyc;
      end
      if (r_done === 1'b1) begin
        r_done_cnt++;
        r_done_cyc = cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    busy_cnt = 0; done_cnt = 0; first_busy = -1; last_busy = -1; max_cnt = 0; saw_block = 1'b0;
    r_busy_cnt = 0; r_done_cnt = 0; r_first = -1; r_last = -1; r_done_cyc = -1;
  endtask

  task automatic write1(input logic [7:0] d, input logic [1:0] m);
    s_data = d; parity_mode = m; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit second, input int budget);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk); #1;
      n++;
      done = second ? (r_busy === 1'b0 && r_empty === 1'b1) : (tx_busy === 1'b0 && fifo_empty === 1'b1);
    end
    if (!done) timeout(second ? "wait_idle_dut5" : "wait_idle");
    tick(1);
  endtask

  int          base, s, guard, fb;
  bit          rdy;
  logic [7:0]  got;
  logic [7:0]  words [6] = '{8'h11, 8'h22, 8'h3C, 8'h44, 8'hA5, 8'h5E};
  bit          exp_a5 [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

  initial begin
    clear_mon();
    tick(3);
    reset = 1'b0;
    r_reset = 1'b0;
    @(negedge clk); #1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    check("rst_count", fifo_count, 0);
    check("rst_empty", fifo_empty, 1'b1);
    check("rst_full", fifo_full, 1'b0);
    check("rst_ready", s_ready, 1'b1);
    tick(1);

    // 0xA5, no parity: 40-cycle frame, start bit one cycle after the word appears.
    clear_mon();
    write1(8'hA5, 2'b00);
    base = cyc + 1;
    wait_idle(1'b0, 200);
    check("a5_pre_start", txlog[base], 1'b1);
    check("a5_latency", first_busy - base, 1);
    check("a5_busy_len", busy_cnt, 40);
    check("a5_span", last_busy - first_busy + 1, 40);
    check("a5_done_cnt", done_cnt, 1);
    for (int k = 0; k < 10; k++) check("a5_bit", txlog[first_busy + 4 * k + 2], exp_a5[k]);

    // 0x03 even then odd parity; parity_mode changes mid-frame must not matter.
    tick(2);
    clear_mon();
    write1(8'h03, 2'b01);
    tick(8);
    parity_mode = 2'b00;
    wait_idle(1'b0, 200);
    check("even_len", busy_cnt, FL);
    check("even_bit9", txlog[first_busy + 4 * 9 + 2], PAR_EN ? 1'b0 : 1'b1);
    tick(2);
    clear_mon();
    write1(8'h03, 2'b10);
    tick(8);
    parity_mode = 2'b01;
    wait_idle(1'b0, 200);
    check("odd_len", busy_cnt, FL);
    check("odd_bit9", txlog[first_busy + 4 * 9 + 2], 1'b1);
    parity_mode = 2'b00;

    // Six words with a valid/ready handshake: back-pressure at four, frames contiguous.
    tick(2);
    clear_mon();
    for (int i = 0; i < 6; i++) begin
      s_data = words[i];
      s_valid = 1'b1;
      guard = 0;
      rdy = 1'b0;
      while (!rdy && guard < 200) begin
        rdy = s_ready;
        @(posedge clk); #1;
        guard++;
      end
      if (!rdy) timeout("burst_accept");
    end
    s_valid = 1'b0;
    wait_idle(1'b0, 800);
    check("burst_done_cnt", done_cnt, 6);
    check("burst_busy", busy_cnt, 240);
    check("burst_span", last_busy - first_busy + 1, 240);
    check("burst_max_cnt", max_cnt, 4);
    check("burst_blocked", saw_block, 1'b1);
    for (int f = 0; f < 6; f++) begin
      for (int b = 0; b < 8; b++) got[b] = txlog[first_busy + 40 * f + 4 * (1 + b) + 2];
      check("burst_rx_byte", got, words[f]);
    end

    // Reset in the third data bit with two words still queued.
    tick(2);
    clear_mon();
    write1(8'h00, 2'b00);
    write1(8'h5A, 2'b00);
    write1(8'hC3, 2'b00);
    guard = 0;
    while ((first_busy < 0 || cyc < first_busy + 12) && guard < 100) begin
      @(negedge clk); #1;
      guard++;
    end
    if (first_busy < 0 || cyc != first_busy + 12) timeout("rst_mid_align");
    fb = first_busy;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;
    check("mid_bit2", txlog[fb + 13], 1'b0);
    check("mid_rst_tx", tx, 1'b1);
    check("mid_rst_busy", tx_busy, 1'b0);
    check("mid_rst_empty", fifo_empty, 1'b1);
    check("mid_rst_count", fifo_count, 0);
    tick(1);
    clear_mon();
    tick(100);
    check("post_rst_busy", busy_cnt, 0);
    check("post_rst_done", done_cnt, 0);

    // Second instance: 5 data bits, 2 stop bits.
    clear_mon();
    r_data = 8'hFF; r_valid = 1'b1;
    @(posedge clk); #1;
    r_valid = 1'b0;
    wait_idle(1'b1, 200);
    check("d5_busy", r_busy_cnt, 32);
    check("d5_done_cnt", r_done_cnt, 1);
    check("d5_done_pos", r_done_cyc, r_last);
    check("d5_start", r_txlog[r_first + 2], 1'b0);
    for (int k = 0; k < 5; k++) check("d5_ff_bit", r_txlog[r_first + 4 * (1 + k) + 2], 1'b1);
    check("d5_stop1", r_txlog[r_first + 26], 1'b1);
    check("d5_stop2", r_txlog[r_first + 30], 1'b1);
    tick(2);
    clear_mon();
    r_data = 8'hE0; r_valid = 1'b1;
    @(posedge clk); #1;
    r_valid = 1'b0;
    wait_idle(1'b1, 200);
    check("d5_e0_busy", r_busy_cnt, 32);
    for (int k = 0; k < 5; k++) check("d5_e0_bit", r_txlog[r_first + 4 * (1 + k) + 2], 1'b0);
    check("d5_idle_tx", r_tx, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d comparisons failed so far", fails, tests);
    $fatal(1, "watchdog expired");
  end

endmodule
